bp_cce_dir_sharers_rd: RTL and testbench
========================================

# bp_cce_dir_sharers_rd

Directory way-group reader for the CCE. On a lookup request it reads one directory RAM row per LCE for the target way-group and compares every way's stored tag against the target tag. It consolidates the results into per-LCE hit, way and coherence-state vectors plus a valid flag. It sits directly upstream of the GAD stage and drives that stage's sharers_v_i / sharers_hits_i / sharers_ways_i / sharers_coh_states_i inputs.

## Interface
Parameters:
- num_lce_p, "inv", number of LCEs; one directory row per LCE per way-group
- lce_assoc_p, "inv", ways per LCE set (max associativity over LCE types)
- num_way_groups_p, "inv", way-groups in the directory
- tag_width_p, "inv", directory tag width
- derived: lg_lce_assoc_lp = `BSG_SAFE_CLOG2(lce_assoc_p)`; entry_width_lp = tag_width_p+3; row_width_lp = lce_assoc_p*entry_width_lp; addr_width_lp = `BSG_SAFE_CLOG2(num_way_groups_p*num_lce_p)`

Ports:
- clk_i  in  1  clock; single clock domain
- reset_i  in  1  synchronous, active-high reset
- start_v_i  in  1  lookup request valid
- ready_o  out  1  block can accept a lookup
- way_group_i  in  `BSG_SAFE_CLOG2(num_way_groups_p)`  target way-group, sampled on accept
- tag_i  in  tag_width_p  target tag, sampled on accept
- ram_v_o  out  1  directory RAM read enable
- ram_addr_o  out  addr_width_lp  row address = way_group*num_lce_p + lce
- ram_data_i  in  row_width_lp  row data, valid the cycle after ram_v_o; entry w = bits [w*entry_width_lp +: entry_width_lp], {tag, 3-bit bp_coh_states_e}
- sharers_v_o  out  1  consolidated vectors valid
- sharers_hits_o  out  num_lce_p  per-LCE hit
- sharers_ways_o  out  num_lce_p×lg_lce_assoc_lp  per-LCE hit way
- sharers_coh_states_o  out  num_lce_p×bp_coh_states_e  per-LCE hit state

## Operation
FSM states:
- e_idle:
  - ready_o=1.
  - On start_v_i: latch way_group_i and tag_i, clear all sharers outputs and sharers_v_o, clear the row counter, go to e_read.
- e_read:
  - ram_v_o=1; ram_addr_o = latched way_group*num_lce_p + cnt.
  - cnt increments each cycle.
  - When cnt==num_lce_p-1, go to e_last.
- e_last:
  - ram_v_o=0.
  - Capture the final row, set sharers_v_o, go to e_idle.

Response capture:
- A registered copy of ram_v_o and the row index marks ram_data_i as valid in the following cycle.
- The row for LCE i is written into slot i only.

Per-row compare:
- way w hits iff stored tag == latched tag and stored state != e_COH_I.
- hit[i] = OR over all ways.
- When more than one way hits, the lowest-index way wins; way[i] and state[i] come from that way.
- No hit: hit[i]=0, way[i]=0, state[i]=e_COH_I.

Output holding:
- sharers_* and sharers_v_o hold their values until the next accepted start, which clears them in the accept cycle.
- ready_o=0 in e_read and e_last; start_v_i is ignored there.

## Timing
- Reset: state=e_idle, ready_o=1, ram_v_o=0, ram_addr_o=0, sharers_v_o=0, all sharers vectors 0 (state 0 = e_COH_I).
- Cycle numbering: accept at cycle 0.
  - Cycles 1..N (N=num_lce_p): ram_v_o=1, addresses base+0..base+N-1.
  - Row k data arrives in cycle k+2 and is registered at the end of that cycle.
  - Cycle N+1: e_last.
  - Cycle N+2: sharers_v_o=1, ready_o=1.
- Latency: accept to sharers_v_o = N+2 cycles.
- Back-to-back: a start in cycle N+2 is accepted, and sharers_v_o drops in cycle N+3.
- Throughput: one lookup per N+2 cycles.
- Reset asserted mid-lookup: abort next cycle to reset values. sharers_v_o stays 0, and no further RAM reads are issued.
- Last way-group: the address must not wrap. Max address = num_way_groups_p*num_lce_p-1.
- num_lce_p=1: e_read lasts exactly one cycle.

## Test plan
Configuration for all scenarios: num_lce_p=4, lce_assoc_p=2, tag_width_p=8, num_way_groups_p=4.

- Reset check: assert reset -> ready_o=1, ram_v_o=0, sharers_v_o=0, all vectors 0.
- Single-sharer hit:
  - Stimulus: start way_group=2, tag=0x5A; row addr 9 (LCE1) way1 = {0x5A, e_COH_S}; all other entries miss.
  - Required: addresses 8,9,10,11 in cycles 1–4; sharers_v_o rises in cycle 6; hits=4'b0010, ways[1]=1, states[1]=e_COH_S.
- Match on invalid state:
  - Stimulus: LCE3 way0 = {0x5A, e_COH_I}; LCE0 way0 = {0x5A, e_COH_M}.
  - Required: hits=4'b0001, states[0]=e_COH_M, states[3]=e_COH_I, ways[3]=0.
- Multi-way hit:
  - Stimulus: LCE2 ways 0 and 1 both {0x5A, e_COH_S}.
  - Required: ways[2]=0.
- Busy and back-to-back:
  - Stimulus: start_v_i held high throughout.
  - Required: ready_o=0 in cycles 1–5; second lookup accepted in cycle 6; sharers_v_o=0 in cycle 7; second result valid in cycle 12.
- Mid-lookup reset and last way-group:
  - Stimulus: reset in cycle 3.
  - Required: sharers_v_o never asserts, ram_v_o=0 from cycle 4.
  - Then start way_group=3: addresses 12–15, no wrap.

Source files
------------

// File: rtl/bp_cce_dir_sharers_rd.sv
// Directory way-group reader: walks one RAM row per LCE for a way-group
// and folds each row's tag compare into per-LCE hit/way/state vectors.
module bp_cce_dir_sharers_rd #(
  parameter int num_lce_p = 4,
  parameter int lce_assoc_p = 2,
  parameter int num_way_groups_p = 4,
  parameter int tag_width_p = 8,
  localparam int lg_lce_assoc_lp =
    (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int lg_way_groups_lp =
    (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1,
  localparam int lg_lce_lp =
    (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int entry_width_lp = tag_width_p + 3,
  localparam int row_width_lp = lce_assoc_p * entry_width_lp,
  localparam int addr_width_lp =
    (num_way_groups_p * num_lce_p > 1)
      ? $clog2(num_way_groups_p * num_lce_p) : 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_v_i,
  output logic ready_o,
  input  logic [lg_way_groups_lp-1:0] way_group_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic ram_v_o,
  output logic [addr_width_lp-1:0] ram_addr_o,
  input  logic [row_width_lp-1:0] ram_data_i,
  output logic sharers_v_o,
  output logic [num_lce_p-1:0] sharers_hits_o,
  output logic [num_lce_p*lg_lce_assoc_lp-1:0] sharers_ways_o,
  output logic [num_lce_p*3-1:0] sharers_coh_states_o
);

  localparam logic [2:0] e_COH_I = 3'b000;

  typedef enum logic [1:0] {
    e_idle,
    e_read,
    e_last
  } state_e;

  state_e r_state;
  state_e w_state_n;

  logic [lg_way_groups_lp-1:0] r_wg;
  logic [tag_width_p-1:0] r_tag;
  logic [lg_lce_lp-1:0] r_cnt;
  logic r_rd_v;
  logic [lg_lce_lp-1:0] r_rd_idx;

  logic r_sharers_v;
  logic [num_lce_p-1:0] r_hits;
  logic [num_lce_p*lg_lce_assoc_lp-1:0] r_ways;
  logic [num_lce_p*3-1:0] r_states;

  logic w_ready;
  logic w_ram_v;
  logic w_accept;
  logic w_last_row;
  logic [addr_width_lp-1:0] w_addr;

  logic w_hit;
  logic [lg_lce_assoc_lp-1:0] w_way;
  logic [2:0] w_st;

  assign w_last_row = (r_cnt == lg_lce_lp'(num_lce_p - 1));
  assign w_accept = w_ready & start_v_i;

  always_comb begin
    w_state_n = r_state;
    w_ready = 1'b0;
    w_ram_v = 1'b0;
    unique case (r_state)
      e_idle: begin
        w_ready = 1'b1;
        if (start_v_i) w_state_n = e_read;
      end
      e_read: begin
        w_ram_v = 1'b1;
        if (w_last_row) w_state_n = e_last;
      end
      e_last: begin
        w_state_n = e_idle;
      end
      default: begin
        w_state_n = e_idle;
      end
    endcase
  end

  assign w_addr = (addr_width_lp'(r_wg) * addr_width_lp'(num_lce_p))
                + addr_width_lp'(r_cnt);

  // Scan high to low so the lowest-index valid match is left standing.
  always_comb begin
    w_hit = 1'b0;
    w_way = '0;
    w_st = e_COH_I;
    for (int w = lce_assoc_p - 1; w >= 0; w--) begin
      if ((ram_data_i[w*entry_width_lp+3 +: tag_width_p] == r_tag)
          && (ram_data_i[w*entry_width_lp +: 3] != e_COH_I)) begin
        w_hit = 1'b1;
        w_way = lg_lce_assoc_lp'(w);
        w_st = ram_data_i[w*entry_width_lp +: 3];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_wg <= '0;
      r_tag <= '0;
      r_cnt <= '0;
      r_rd_v <= 1'b0;
      r_rd_idx <= '0;
      r_sharers_v <= 1'b0;
      r_hits <= '0;
      r_ways <= '0;
      r_states <= '0;
    end else begin
      r_state <= w_state_n;
      r_rd_v <= w_ram_v;
      r_rd_idx <= r_cnt;
      if (w_accept) begin
        r_wg <= way_group_i;
        r_tag <= tag_i;
        r_cnt <= '0;
        r_sharers_v <= 1'b0;
        r_hits <= '0;
        r_ways <= '0;
        r_states <= '0;
      end else begin
        if ((r_state == e_read) && !w_last_row)
          r_cnt <= r_cnt + lg_lce_lp'(1);
        if (r_rd_v) begin
          r_hits[r_rd_idx] <= w_hit;
          r_ways[r_rd_idx*lg_lce_assoc_lp +: lg_lce_assoc_lp] <= w_way;
          r_states[r_rd_idx*3 +: 3] <= w_st;
        end
        if (r_state == e_last) r_sharers_v <= 1'b1;
      end
    end
  end

  assign ready_o = w_ready;
  assign ram_v_o = w_ram_v;
  assign ram_addr_o = w_ram_v ? w_addr : '0;
  assign sharers_v_o = r_sharers_v;
  assign sharers_hits_o = r_hits;
  assign sharers_ways_o = r_ways;
  assign sharers_coh_states_o = r_states;

endmodule

// File: tb/tb_bp_cce_dir_sharers_rd.sv
// Scoreboard bench for bp_cce_dir_sharers_rd: directed lookups against a
// small behavioral directory RAM, with address and result monitors.
module tb_bp_cce_dir_sharers_rd;

  localparam logic [2:0] I = 3'd0;
  localparam logic [2:0] S = 3'd1;
  localparam logic [2:0] E = 3'd2;
  localparam logic [2:0] F = 3'd3;
  localparam logic [2:0] M = 3'd7;

  logic clk = 1'b0;
  logic reset_i;
  logic start_v_i;
  logic ready_o;
  logic [1:0] way_group_i;
  logic [7:0] tag_i;
  logic ram_v_o;
  logic [3:0] ram_addr_o;
  logic [21:0] ram_data_i;
  logic sharers_v_o;
  logic [3:0] sharers_hits_o;
  logic [3:0] sharers_ways_o;
  logic [11:0] sharers_coh_states_o;

  bp_cce_dir_sharers_rd #(
    .num_lce_p(4),
    .lce_assoc_p(2),
    .num_way_groups_p(4),
    .tag_width_p(8)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .start_v_i(start_v_i),
    .ready_o(ready_o),
    .way_group_i(way_group_i),
    .tag_i(tag_i),
    .ram_v_o(ram_v_o),
    .ram_addr_o(ram_addr_o),
    .ram_data_i(ram_data_i),
    .sharers_v_o(sharers_v_o),
    .sharers_hits_o(sharers_hits_o),
    .sharers_ways_o(sharers_ways_o),
    .sharers_coh_states_o(sharers_coh_states_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] hits;
    logic [3:0] ways;
    logic [11:0] st;
    int cyc;
  } res_t;

  typedef struct {
    logic [3:0] a;
    int cyc;
  } adr_t;

  res_t rq[$];
  adr_t aq[$];
  logic [21:0] mem [16];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic prev_v = 1'b0;
  logic req_v = 1'b0;
  logic [3:0] req_a = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] ent(input logic [7:0] t,
                                      input logic [2:0] s);
    return {t, s};
  endfunction

  // Synchronous-read RAM: request seen in cycle k, data driven in k+1.
  always @(negedge clk) begin
    req_v = (ram_v_o === 1'b1);
    req_a = ram_addr_o;
  end

  always @(posedge clk) begin
    #1;
    ram_data_i = req_v ? mem[req_a] : '0;
  end

  always @(negedge clk) begin
    adr_t a;
    if (ram_v_o === 1'b1) begin
      if (aq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ram_read addr=%0d cyc=%0d", ram_addr_o, cyc);
      end else begin
        a = aq.pop_front();
        chk("ram_addr", ram_addr_o, a.a);
        chk("ram_cyc", cyc, a.cyc);
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if ((sharers_v_o === 1'b1) && (prev_v !== 1'b1)) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got=1 exp=0 cyc=%0d", cyc);
      end else begin
        e = rq.pop_front();
        chk("res_cyc", cyc, e.cyc);
        chk("res_hits", sharers_hits_o, e.hits);
        chk("res_ways", sharers_ways_o, e.ways);
        chk("res_states", sharers_coh_states_o, e.st);
        chk("res_ready", ready_o, 1);
      end
    end
    prev_v = sharers_v_o;
  end

  task automatic push_exp(input logic [1:0] wg, input int c0, input int na,
                          input bit res, input logic [3:0] h,
                          input logic [3:0] w, input logic [11:0] s);
    adr_t a;
    res_t r;
    for (int k = 0; k < na; k++) begin
      a.a = 4'(int'(wg) * 4 + k);
      a.cyc = c0 + 1 + k;
      aq.push_back(a);
    end
    if (res) begin
      r.hits = h;
      r.ways = w;
      r.st = s;
      r.cyc = c0 + 6;
      rq.push_back(r);
    end
  endtask

  task automatic lookup(input logic [1:0] wg, input logic [7:0] tg,
                        input int na, input bit res, input logic [3:0] h,
                        input logic [3:0] w, input logic [11:0] s,
                        output int c0);
    @(posedge clk);
    #1;
    way_group_i = wg;
    tag_i = tg;
    start_v_i = 1'b1;
    c0 = cyc;
    push_exp(wg, c0, na, res, h, w, s);
    @(posedge clk);
    #1;
    start_v_i = 1'b0;
  endtask

  initial begin
    int c0;
    reset_i = 1'b1;
    start_v_i = 1'b0;
    way_group_i = '0;
    tag_i = '0;
    ram_data_i = '0;
    // way-group 0: multi-way hits
    mem[0] = {ent(8'h12, S), ent(8'h34, S)};
    mem[1] = {ent(8'h5A, I), ent(8'h5B, M)};
    mem[2] = {ent(8'h5A, S), ent(8'h5A, S)};
    mem[3] = {ent(8'h5A, S), ent(8'h5A, E)};
    // way-group 1: tag match on invalid state
    mem[4] = {ent(8'h33, S), ent(8'h5A, M)};
    mem[5] = {ent(8'hA4, M), ent(8'h5B, S)};
    mem[6] = {ent(8'hA5, I), ent(8'h00, S)};
    mem[7] = {ent(8'hA5, S), ent(8'h5A, I)};
    // way-group 2: single sharer
    mem[8] = {ent(8'h5B, S), ent(8'hA5, M)};
    mem[9] = {ent(8'h5A, S), ent(8'h11, M)};
    mem[10] = {ent(8'h00, I), ent(8'hDA, E)};
    mem[11] = {ent(8'h7A, S), ent(8'h58, E)};
    // way-group 3: last group
    mem[12] = {ent(8'h00, S), ent(8'h5A, E)};
    mem[13] = {ent(8'hA5, S), ent(8'h5A, I)};
    mem[14] = {ent(8'h02, M), ent(8'h01, M)};
    mem[15] = {ent(8'h5A, F), ent(8'h5A, I)};

    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_ram_v", ram_v_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_v", sharers_v_o, 0);
    chk("rst_hits", sharers_hits_o, 0);
    chk("rst_ways", sharers_ways_o, 0);
    chk("rst_states", sharers_coh_states_o, 0);

    lookup(2'd2, 8'h5A, 4, 1'b1, 4'b0010, 4'b0010, 12'h008, c0);
    repeat (8) @(posedge clk);
    lookup(2'd1, 8'h5A, 4, 1'b1, 4'b0001, 4'b0000, 12'h007, c0);
    repeat (8) @(posedge clk);
    lookup(2'd0, 8'h5A, 4, 1'b1, 4'b1100, 4'b0000, 12'h440, c0);
    repeat (8) @(posedge clk);

    // back-to-back with start held high
    @(posedge clk);
    #1;
    way_group_i = 2'd2;
    tag_i = 8'h5A;
    start_v_i = 1'b1;
    c0 = cyc;
    push_exp(2'd2, c0, 4, 1'b1, 4'b0010, 4'b0010, 12'h008);
    @(negedge clk);
    chk("b2b_ready0", ready_o, 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("b2b_busy", ready_o, 0);
      if (i == 1) begin
        way_group_i = 2'd1;
        tag_i = 8'hA5;
        push_exp(2'd1, c0 + 6, 4, 1'b1, 4'b1000, 4'b1000, 12'h200);
      end
    end
    @(negedge clk);
    chk("b2b_ready6", ready_o, 1);
    @(posedge clk);
    #1;
    start_v_i = 1'b0;
    @(negedge clk);
    chk("b2b_v_drop", sharers_v_o, 0);
    repeat (8) @(posedge clk);

    // reset in cycle 3 of a lookup
    lookup(2'd2, 8'h5A, 3, 1'b0, 4'b0, 4'b0, 12'h0, c0);
    while (cyc < c0 + 3) begin
      @(posedge clk);
      #1;
    end
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_ram_v", ram_v_o, 0);
      chk("mrst_v", sharers_v_o, 0);
    end
    chk("mrst_ready", ready_o, 1);
    chk("mrst_hits", sharers_hits_o, 0);
    chk("mrst_states", sharers_coh_states_o, 0);

    lookup(2'd3, 8'h5A, 4, 1'b1, 4'b1001, 4'b1000, 12'h602, c0);

    for (int i = 0; i < 50 && (rq.size() != 0 || aq.size() != 0); i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("res_queue_empty", rq.size(), 0);
    chk("addr_queue_empty", aq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
